// File: rtl/demux_stream_router_pkg.sv
// Shared constants for the 1-to-4 demux stream router: channel count, select width, stage states.
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;
endpackage

// File: rtl/demux_stream_router_if.sv
// Stream-in and per-channel-out bundle of the demux router; slave is the router's view.
// Handshake: a word moves on an edge where in_valid & in_ready; channel k's word is consumed on an
// edge where out_valid[k] & out_ack[k]; out_ack[k] with out_valid[k]=0 has no effect.
interface demux_stream_router_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SEL_W-1:0]      in_sel;
  logic [N_CH-1:0]       out_valid;
  logic [N_CH*WIDTH-1:0] out_data;
  logic [N_CH-1:0]       out_ack;

  modport master (
    output in_valid, in_data, in_sel, out_ack,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ack,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_chan_reg.sv
// One-word channel holding register: load sets valid and captures data, ack clears valid.
module demux_chan_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  // A load in the same cycle as an ack wins, so valid never drops across a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_stream_router.sv
// Stream front-end for the 1-to-4 demux: one-word stage with target select, four channel registers.
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_rr,
  input  logic                 flush,
  demux_stream_router_if.slave bus,
  output logic [SEL_W-1:0]     dmx_s,
  output logic [WIDTH-1:0]     dmx_d,
  output logic                 busy,
  output logic [0:0]           stage_state
);
  logic [0:0]            state;
  logic [SEL_W-1:0]      tgt;
  logic [SEL_W-1:0]      rr_ptr;
  logic [SEL_W-1:0]      pick;
  logic [WIDTH-1:0]      stage_data;
  logic                  can_deliver;
  logic                  deliver;
  logic                  accept;
  logic [N_CH-1:0]       ch_valid;
  logic [N_CH-1:0]       ch_load;
  logic [N_CH*WIDTH-1:0] ch_data;

  // in_ready passes the deliver condition through so a full-speed stream never bubbles.
  always_comb begin
    can_deliver  = (state == ST_LOADED) && (!ch_valid[tgt] || bus.out_ack[tgt]);
    deliver      = can_deliver && !flush;
    bus.in_ready = !flush && ((state == ST_EMPTY) || can_deliver);
    accept       = bus.in_valid && bus.in_ready;
    pick         = mode_rr ? rr_ptr : bus.in_sel;
  end

  always_comb begin
    ch_load = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_load[k] = deliver && (tgt == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      tgt        <= '0;
      rr_ptr     <= '0;
      stage_data <= '0;
    end else if (flush) begin
      state      <= ST_EMPTY;
      tgt        <= '0;
      rr_ptr     <= '0;
      stage_data <= '0;
    end else if (accept) begin
      state      <= ST_LOADED;
      tgt        <= pick;
      stage_data <= bus.in_data;
      if (mode_rr) rr_ptr <= rr_ptr + SEL_W'(1);
    end else if (deliver) begin
      state <= ST_EMPTY;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_chan_reg #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .load  (ch_load[k]),
      .ack   (bus.out_ack[k]),
      .d     (stage_data),
      .valid (ch_valid[k]),
      .q     (ch_data[k*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    bus.out_valid = ch_valid;
    bus.out_data  = ch_data;
    dmx_s         = tgt;
    dmx_d         = (state == ST_LOADED) ? stage_data : '0;
    busy          = state[0] || (|ch_valid);
    stage_state   = state;
  end
endmodule

// File: tb/tb_demux_stream_router.sv
// Directed bench for demux_stream_router: addressed, round-robin, backpressure, swap, flush, reset.
module tb_demux_stream_router;
  import demux_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode_rr = 1'b0;
  logic             flush = 1'b0;
  logic [SEL_W-1:0] dmx_s;
  logic [0:0]       dmx_d;
  logic             busy;
  logic [0:0]       stage_state;
  logic [3:0]       bits;
  int               n_vec = 0;
  int               n_err = 0;

  demux_stream_router_if #(.WIDTH(1)) bus ();

  demux_stream_router #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_rr     (mode_rr),
    .flush       (flush),
    .bus         (bus),
    .dmx_s       (dmx_s),
    .dmx_d       (dmx_d),
    .busy        (busy),
    .stage_state (stage_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic [1:0] s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0);
    bus.out_ack = 4'b0000;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_dmx_s", 32'(dmx_s), 32'h0);
    check("rst_dmx_d", 32'(dmx_d), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(stage_state), 32'h0);
    rst_n = 1'b1;
    tick();

    // addressed: words 1,0,1,1 to channels 0..3, acks held
    bits = 4'b1101;
    mode_rr = 1'b0;
    bus.out_ack = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, bits[i], 2'(i));
      else drive(1'b0, 1'b0, 2'd0);
      @(negedge clk);
      if (i < 4) check("addr_in_ready", 32'(bus.in_ready), 32'h1);
      if (i >= 1 && i <= 4) check("addr_dmx_d", 32'(dmx_d), 32'(bits[i-1]));
      if (i >= 2) check("addr_onehot", 32'(bus.out_valid), 32'h1 << (i - 2));
      tick();
    end
    @(negedge clk);
    check("addr_drained", 32'(bus.out_valid), 32'h0);
    check("addr_out_data", 32'(bus.out_data), 32'hd);
    check("addr_state", 32'(stage_state), 32'h0);
    tick();

    // round-robin: 6 back-to-back words, targets 0,1,2,3,0,1
    mode_rr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1'b1, 1'(i % 2), 2'd3);
      else drive(1'b0, 1'b0, 2'd0);
      @(negedge clk);
      if (i < 6) check("rr_in_ready", 32'(bus.in_ready), 32'h1);
      if (i >= 1 && i <= 6) check("rr_dmx_s", 32'(dmx_s), 32'((i - 1) % 4));
      if (i >= 2) begin
        check("rr_onehot", 32'(bus.out_valid), 32'h1 << ((i - 2) % 4));
        check("rr_data", 32'(bus.out_data[2'((i - 2) % 4)]), 32'((i - 2) % 2));
      end
      tick();
    end

    // backpressure on channel 2
    mode_rr = 1'b0;
    bus.out_ack = 4'b0000;
    drive(1'b1, 1'b0, 2'd2);
    tick();
    drive(1'b0, 1'b0, 2'd0);
    tick();
    @(negedge clk);
    check("bp_ch2_full", 32'(bus.out_valid), 32'h4);
    check("bp_ch2_data0", 32'(bus.out_data[2]), 32'h0);
    tick();
    drive(1'b1, 1'b1, 2'd2);
    tick();
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("bp_state", 32'(stage_state), 32'h1);
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    check("bp_dmx_s", 32'(dmx_s), 32'h2);
    check("bp_dmx_d", 32'(dmx_d), 32'h1);
    check("bp_busy", 32'(busy), 32'h1);
    tick();
    @(negedge clk);
    check("bp_hold_state", 32'(stage_state), 32'h1);
    check("bp_hold_data", 32'(bus.out_data[2]), 32'h0);
    tick();
    bus.out_ack = 4'b0100;
    @(negedge clk);
    check("bp_ack_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.out_ack = 4'b0000;
    @(negedge clk);
    check("bp_swap_valid", 32'(bus.out_valid), 32'h4);
    check("bp_swap_data", 32'(bus.out_data[2]), 32'h1);
    check("bp_swap_state", 32'(stage_state), 32'h0);
    tick();
    bus.out_ack = 4'b0100;
    tick();
    bus.out_ack = 4'b0000;
    @(negedge clk);
    check("bp_cleared", 32'(bus.out_valid), 32'h0);
    tick();

    // same-cycle ack and deliver on channel 0 with a new accept
    drive(1'b1, 1'b1, 2'd0);
    tick();
    drive(1'b1, 1'b0, 2'd0);
    @(negedge clk);
    check("sim_ready_a", 32'(bus.in_ready), 32'h1);
    tick();
    drive(1'b1, 1'b1, 2'd0);
    bus.out_ack = 4'b0001;
    @(negedge clk);
    check("sim_ready_b", 32'(bus.in_ready), 32'h1);
    check("sim_valid_a", 32'(bus.out_valid), 32'h1);
    check("sim_data_a", 32'(bus.out_data[0]), 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("sim_valid_b", 32'(bus.out_valid), 32'h1);
    check("sim_data_b", 32'(bus.out_data[0]), 32'h0);
    check("sim_state_b", 32'(stage_state), 32'h1);
    check("sim_dmx_d", 32'(dmx_d), 32'h1);
    tick();
    bus.out_ack = 4'b0000;
    @(negedge clk);
    check("sim_valid_c", 32'(bus.out_valid), 32'h1);
    check("sim_data_c", 32'(bus.out_data[0]), 32'h1);
    check("sim_state_c", 32'(stage_state), 32'h0);
    tick();
    bus.out_ack = 4'b0001;
    tick();
    bus.out_ack = 4'b0000;

    // flush with all channels full and a word staged
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'(i % 2), 2'(i % 4));
      tick();
    end
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("fl_all_full", 32'(bus.out_valid), 32'hf);
    check("fl_staged", 32'(stage_state), 32'h1);
    check("fl_blocked", 32'(bus.in_ready), 32'h0);
    tick();
    mode_rr = 1'b1;
    flush = 1'b1;
    drive(1'b1, 1'b1, 2'd3);
    @(negedge clk);
    check("fl_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("fl_out_valid", 32'(bus.out_valid), 32'h0);
    check("fl_state", 32'(stage_state), 32'h0);
    check("fl_busy", 32'(busy), 32'h0);
    tick();
    bus.out_ack = 4'b1111;
    drive(1'b1, 1'b1, 2'd3);
    tick();
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("fl_rr_dmx_s", 32'(dmx_s), 32'h0);
    tick();
    @(negedge clk);
    check("fl_rr_target", 32'(bus.out_valid), 32'h1);
    tick();

    // asynchronous reset mid-stream (rr_ptr is 1 here: targets 1,2,3)
    bus.out_ack = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd0);
      tick();
    end
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("mr_pre_dmx_s", 32'(dmx_s), 32'h3);
    check("mr_pre_valid", 32'(bus.out_valid), 32'h6);
    #1 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(bus.out_valid), 32'h0);
    check("mr_in_ready", 32'(bus.in_ready), 32'h1);
    check("mr_dmx_s", 32'(dmx_s), 32'h0);
    check("mr_state", 32'(stage_state), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ack = 4'b1111;
    drive(1'b1, 1'b1, 2'd2);
    tick();
    drive(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("mr_rr_dmx_s", 32'(dmx_s), 32'h0);
    tick();
    @(negedge clk);
    check("mr_rr_target", 32'(bus.out_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
